// File: rtl/clk_divider.sv
// Integer clock divider: oclk has a period of N clk cycles and is high for N/2 of them.
// Even N uses one posedge register; odd N combines a posedge and a negedge register.
module clk_divider #(
    parameter int N = 24
) (
    input  logic clk,
    input  logic rst_n,
    output logic oclk
);

    localparam int CW = (N < 2) ? 1 : $clog2(N);

    if (N < 2) begin : g_bad_n
        $error("clk_divider: parameter N must be at least 2, got %0d", N);
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // cnt_d is the count after the coming edge, so the edge e after release sees e mod N.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    if ((N % 2) == 0) begin : g_even
        logic oclk_q;
        logic oclk_d;

        always_comb begin
            oclk_d = (cnt_d >= CW'(N / 2));
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                oclk_q <= 1'b0;
            end else begin
                oclk_q <= oclk_d;
            end
        end

        assign oclk = oclk_q;
    end else begin : g_odd
        logic p_q;
        logic p_d;
        logic run_q;
        logic run_d;
        logic q_q;
        logic q_d;

        // p is high for (N-1)/2 whole cycles; q extends it by the trailing half cycle.
        always_comb begin
            p_d   = (cnt_d >= CW'((N - 1) / 2)) && (cnt_d <= CW'(N - 2));
            run_d = rst_n;
            q_d   = p_q & run_q;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                p_q <= 1'b0;
            end else begin
                p_q <= p_d;
            end
            run_q <= run_d;
        end

        always_ff @(negedge clk) begin
            q_q <= q_d;
        end

        // run_q masks q from the reset edge so no half-cycle tail survives a reset.
        assign oclk = p_q | (q_q & run_q);
    end

endmodule

// File: tb/tb_clk_divider.sv
// Bench for clk_divider at N=24, N=2 and N=5: drivers push expected oclk edges
// (time, level) into queues; per-instance monitors pop and compare on every oclk change.
module tb_clk_divider;

    localparam int W = 49;

    logic clk = 1'b0;
    logic rst24;
    logic rst2;
    logic rst5;
    logic oclk24;
    logic oclk2;
    logic oclk5;

    logic [W-1:0] exp24_q[$];
    logic [W-1:0] exp2_q[$];
    logic [W-1:0] exp5_q[$];

    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;

    always #5 clk = ~clk;

    clk_divider #(.N(24)) u_div24 (.clk(clk), .rst_n(rst24), .oclk(oclk24));
    clk_divider #(.N(2))  u_div2  (.clk(clk), .rst_n(rst2),  .oclk(oclk2));
    clk_divider #(.N(5))  u_div5  (.clk(clk), .rst_n(rst5),  .oclk(oclk5));

    function automatic logic [W-1:0] ev(input longint t, input logic v);
        return {t[47:0], v};
    endfunction

    task automatic check_level(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: oclk=%b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_edge(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: oclk went to %b at t=%0d, expected %b at t=%0d",
                     name, act[0], act[W-1:1], exp[0], exp[W-1:1]);
        end
    endtask

    task automatic check_empty(input string name, input int remaining);
        checks++;
        if (remaining != 0) begin
            errors++;
            $display("FAIL %s: %0d expected edges never seen, required 0", name, remaining);
        end
    endtask

    // Monitors: every oclk change must match the head of that instance's queue.
    initial begin
        logic [W-1:0] e;
        wait (mon_on);
        forever begin
            @(oclk24);
            if (exp24_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL n24_edge: unexpected oclk=%b at t=%0t, required no edge", oclk24, $time);
            end else begin
                e = exp24_q.pop_front();
                cmp_edge("n24_edge", {48'($time), oclk24}, e);
            end
        end
    end

    initial begin
        logic [W-1:0] e;
        wait (mon_on);
        forever begin
            @(oclk2);
            if (exp2_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL n2_edge: unexpected oclk=%b at t=%0t, required no edge", oclk2, $time);
            end else begin
                e = exp2_q.pop_front();
                cmp_edge("n2_edge", {48'($time), oclk2}, e);
            end
        end
    end

    initial begin
        logic [W-1:0] e;
        wait (mon_on);
        forever begin
            @(oclk5);
            if (exp5_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL n5_edge: unexpected oclk=%b at t=%0t, required no edge", oclk5, $time);
            end else begin
                e = exp5_q.pop_front();
                cmp_edge("n5_edge", {48'($time), oclk5}, e);
            end
        end
    end

    // Edge e after release lands at tp + 10*e, tp being the edge before release.
    task automatic drive_n24();
        longint tp;
        rst24 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (50) @(posedge clk);
            #2 check_level("n24_in_reset", oclk24, 1'b0);
        end
        @(posedge clk);
        tp = $time;
        #1 rst24 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            exp24_q.push_back(ev(tp + 10 * (24 * k + 12), 1'b1));
            exp24_q.push_back(ev(tp + 10 * (24 * k + 24), 1'b0));
        end
        repeat (480) @(posedge clk);
        exp24_q.push_back(ev(tp + 10 * 492, 1'b1));
        exp24_q.push_back(ev(tp + 10 * 497, 1'b0));
        repeat (16) @(posedge clk);
        #1 rst24 = 1'b0;
        repeat (6) @(posedge clk);
        #2 check_level("n24_mid_reset", oclk24, 1'b0);
        @(posedge clk);
        tp = $time;
        #1 rst24 = 1'b1;
        exp24_q.push_back(ev(tp + 120, 1'b1));
        exp24_q.push_back(ev(tp + 240, 1'b0));
        exp24_q.push_back(ev(tp + 360, 1'b1));
        exp24_q.push_back(ev(tp + 480, 1'b0));
        repeat (48) @(posedge clk);
        #1 rst24 = 1'b0;
    endtask

    task automatic drive_n2();
        longint tp;
        rst2 = 1'b0;
        repeat (10) @(posedge clk);
        #2 check_level("n2_in_reset", oclk2, 1'b0);
        @(posedge clk);
        tp = $time;
        #1 rst2 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            exp2_q.push_back(ev(tp + 10 * (2 * k + 1), 1'b1));
            exp2_q.push_back(ev(tp + 10 * (2 * k + 2), 1'b0));
        end
        repeat (20) @(posedge clk);
        #1 rst2 = 1'b0;
    endtask

    task automatic drive_n5();
        longint tp;
        rst5 = 1'b0;
        repeat (10) @(posedge clk);
        #2 check_level("n5_in_reset", oclk5, 1'b0);
        @(posedge clk);
        tp = $time;
        #1 rst5 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp5_q.push_back(ev(tp + 10 * (5 * k + 2), 1'b1));
            exp5_q.push_back(ev(tp + 10 * (5 * k + 4) + 5, 1'b0));
        end
        repeat (30) @(posedge clk);
        // One-cycle reset pulse sampled at edge 33, while oclk is high.
        exp5_q.push_back(ev(tp + 320, 1'b1));
        exp5_q.push_back(ev(tp + 330, 1'b0));
        repeat (2) @(posedge clk);
        #1 rst5 = 1'b0;
        @(posedge clk);
        tp = $time;
        #1 rst5 = 1'b1;
        #1 check_level("n5_pulse_edge", oclk5, 1'b0);
        #5 check_level("n5_pulse_after_negedge", oclk5, 1'b0);
        exp5_q.push_back(ev(tp + 20, 1'b1));
        exp5_q.push_back(ev(tp + 45, 1'b0));
        exp5_q.push_back(ev(tp + 70, 1'b1));
        exp5_q.push_back(ev(tp + 95, 1'b0));
        repeat (10) @(posedge clk);
        #1 rst5 = 1'b0;
    endtask

    initial begin
        rst24 = 1'b0;
        rst2  = 1'b0;
        rst5  = 1'b0;
        repeat (3) @(posedge clk);
        #2 mon_on = 1'b1;
        check_level("n24_reset_state", oclk24, 1'b0);
        check_level("n2_reset_state", oclk2, 1'b0);
        check_level("n5_reset_state", oclk5, 1'b0);
        fork
            drive_n24();
            drive_n2();
            drive_n5();
        join
        repeat (60) @(posedge clk);
        check_empty("n24_all_edges_seen", exp24_q.size());
        check_empty("n2_all_edges_seen", exp2_q.size());
        check_empty("n5_all_edges_seen", exp5_q.size());
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
